ram_sp_clr: RTL and testbench

Parametrised single-port synchronous RAM that succeeds the fixed 64x16 `ram64`. It adds configurable width and depth, a registered read with a valid strobe, and a selectable read-during-write mode. A built-in clear engine zeroes the whole array after reset or on request. It serves as the generic storage macro for register files, scratch buffers and FIFO backing stores in the lab designs.

---
 rtl/ram_sp_clr.sv | 96 +++++++++
 tb/tb_ram_sp_clr.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with registered read, valid strobe and
// a sweep engine that zeroes the array after reset or on request.
module ram_sp_clr #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 6,
  parameter int READ_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              w,
  input  logic              r,
  input  logic [ADDR_W-1:0] add,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  output logic              rd_valid,
  input  logic              clr,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    we      = 1'b0;
    wa      = add;
    wd      = d_in;
    unique case (state_q)
      CLEAR: begin
        we    = 1'b1;
        wa    = cnt_q;
        wd    = '0;
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = IDLE;
      end
      IDLE: begin
        // clr wins over any access on the same edge
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (en) begin
          we = w;
          if (r) begin
            vld_d = 1'b1;
            if (w && READ_MODE == 1) dout_d = d_in;
            else                     dout_d = mem[add];
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign d_out    = dout_q;
  assign rd_valid = vld_q;
  assign busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed bench for ram_sp_clr: default, write-first and 8x8 instances.
module tb_ram_sp_clr;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, w, r, clr;
  logic [5:0]  add;
  logic [15:0] d_in;
  logic [15:0] dout0, dout1;
  logic        vld0, vld1, busy0, busy1;

  logic        en2, w2, r2, clr2;
  logic [2:0]  add2;
  logic [7:0]  din2, dout2;
  logic        vld2, busy2;

  int checks = 0;
  int errors = 0;
  int n, e2, bad, a;

  always #5 clk = ~clk;

  ram_sp_clr #(.DATA_W(16), .ADDR_W(6), .READ_MODE(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .w(w), .r(r), .add(add),
    .d_in(d_in), .d_out(dout0), .rd_valid(vld0), .clr(clr),
    .busy(busy0)
  );

  ram_sp_clr #(.DATA_W(16), .ADDR_W(6), .READ_MODE(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .w(w), .r(r), .add(add),
    .d_in(d_in), .d_out(dout1), .rd_valid(vld1), .clr(clr),
    .busy(busy1)
  );

  ram_sp_clr #(.DATA_W(8), .ADDR_W(3), .READ_MODE(0)) u2 (
    .clk(clk), .rst(rst), .en(en2), .w(w2), .r(r2), .add(add2),
    .d_in(din2), .d_out(dout2), .rd_valid(vld2), .clr(clr2),
    .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sweep_len(output int nn, output int ee, output int bb);
    nn = 0;
    ee = 0;
    bb = 0;
    while (busy0 && nn < 200) begin
      tick();
      nn++;
      if (!busy2 && ee == 0) ee = nn;
      if (vld0 !== 1'b0 || vld1 !== 1'b0) bb++;
    end
  endtask

  initial begin
    rst = 1'b1;
    en = 0; w = 0; r = 0; clr = 0; add = '0; d_in = '0;
    en2 = 0; w2 = 0; r2 = 0; clr2 = 0; add2 = '0; din2 = '0;
    #1;
    chk("rst_busy", 64'(busy0), 64'd1);
    chk("rst_dout", 64'(dout0), 64'd0);
    chk("rst_vld", 64'(vld0), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    // power-up sweep; reads requested throughout must be ignored
    en = 1; r = 1; add = 6'd7;
    sweep_len(n, e2, bad);
    chk("sweep_edges", 64'(n), 64'd64);
    chk("sweep_edges_8", 64'(e2), 64'd8);
    chk("sweep_no_vld", 64'(bad), 64'd0);
    chk("sweep_dout", 64'(dout0), 64'd0);

    add = 6'd45;
    tick();
    chk("post_rd_vld", 64'(vld0), 64'd1);
    chk("post_rd_dout", 64'(dout0), 64'd0);
    r = 0; en = 0;

    // aliasing on the 8-deep instance
    a = 11;
    en2 = 1; w2 = 1; add2 = a[2:0]; din2 = 8'hA5;
    tick();
    w2 = 0; r2 = 1; add2 = 3'd3;
    tick();
    chk("alias_dout", 64'(dout2), 64'hA5);
    chk("alias_vld", 64'(vld2), 64'd1);
    en2 = 0; r2 = 0;

    for (int i = 0; i < 8; i++) begin
      en = 1; w = 1; add = 6'(2 + 8 * i); d_in = 16'(i + 1);
      tick();
    end
    en = 0; w = 1; add = 6'd2; d_in = 16'h0077;
    tick();
    w = 0; r = 1;
    tick();
    chk("en0_no_vld", 64'(vld0), 64'd0);

    en = 1;
    for (int i = 0; i < 8; i++) begin
      add = 6'(2 + 8 * i);
      tick();
      chk("seq_rd_dout", 64'(dout0), 64'(i + 1));
      chk("seq_rd_vld", 64'(vld0), 64'd1);
    end
    r = 0;
    tick();
    chk("idle_vld", 64'(vld0), 64'd0);
    chk("idle_hold", 64'(dout0), 64'd8);

    // same-address read and write
    w = 1; add = 6'd32; d_in = 16'd9;
    tick();
    r = 1; d_in = 16'd10;
    tick();
    chk("rdw_first", 64'(dout0), 64'd9);
    chk("wr_first", 64'(dout1), 64'd10);
    w = 0;
    tick();
    chk("rdw_after0", 64'(dout0), 64'd10);
    chk("rdw_after1", 64'(dout1), 64'd10);
    r = 0;

    for (int i = 0; i < 64; i++) begin
      w = 1; add = 6'(i); d_in = 16'hFFFF;
      tick();
    end
    w = 0; r = 1; add = 6'd3;
    tick();
    chk("fill_rd", 64'(dout0), 64'hFFFF);

    // clear request together with a write that must be dropped
    clr = 1; w = 1; r = 0; add = 6'd3; d_in = 16'd5;
    tick();
    clr = 0; w = 0; r = 1;
    chk("clr_busy", 64'(busy0), 64'd1);
    sweep_len(n, e2, bad);
    chk("clr_edges", 64'(n), 64'd64);
    chk("clr_no_vld", 64'(bad), 64'd0);
    chk("clr_hold", 64'(dout0), 64'hFFFF);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      add = 6'(i);
      tick();
      if (dout0 !== 16'd0 || vld0 !== 1'b1) bad++;
    end
    chk("clr_all_zero", 64'(bad), 64'd0);
    r = 0;

    // reset in the middle of a sweep
    w = 1; add = 6'd20; d_in = 16'd7;
    tick();
    w = 0; r = 1;
    tick();
    chk("pre_rst_rd", 64'(dout0), 64'd7);
    r = 0; en = 0;
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 30; i++) tick();
    chk("mid_busy", 64'(busy0), 64'd1);
    rst = 1;
    #1;
    chk("mid_rst_busy", 64'(busy0), 64'd1);
    chk("mid_rst_dout", 64'(dout0), 64'd0);
    tick();
    rst = 0;
    sweep_len(n, e2, bad);
    chk("restart_edges", 64'(n), 64'd64);
    en = 1; r = 1; add = 6'd20;
    tick();
    chk("restart_rd", 64'(dout0), 64'd0);
    chk("restart_vld", 64'(vld0), 64'd1);
    en = 0; r = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
